// File: rtl/det_rr_sched.sv
// det_rr_sched: one overlapping-1011 Moore detector time-shared among NCH
// serial channels. Each channel keeps its own 3-bit detector context; a
// round-robin arbiter picks one eligible channel per cycle and only that
// channel's context advances.
// Optional build macro DET_RR_SCHED_CNT_EN adds per-channel saturating
// detection counters with a combinational read port (i_cnt_sel / o_cnt).

module det_rr_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gnt,
  input  logic       clr,
  input  logic       b,
  output logic       hit
`ifdef DET_RR_SCHED_CNT_EN
  ,
  output logic [7:0] cnt
`endif
);

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    GET_1    = 3'd1,
    GET_10   = 3'd2,
    GET_101  = 3'd3,
    GET_1011 = 3'd4
  } ctx_t;

  ctx_t ctx, ctx_nxt, step;

  // Detector transition for the incoming bit; unused encodings behave as INIT
  always_comb begin
    step = INIT;
    case (ctx)
      INIT:     step = b ? GET_1    : INIT;
      GET_1:    step = b ? GET_1    : GET_10;
      GET_10:   step = b ? GET_101  : INIT;
      GET_101:  step = b ? GET_1011 : GET_10;
      GET_1011: step = b ? GET_1    : GET_10;
      default:  step = b ? GET_1    : INIT;
    endcase
  end

  // Clear wins over any update; otherwise only a granted lane advances
  always_comb begin
    ctx_nxt = ctx;
    hit     = 1'b0;
    if (clr) begin
      ctx_nxt = INIT;
    end else if (gnt) begin
      ctx_nxt = step;
      hit     = (step == GET_1011);
    end
  end

  // Context register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctx <= INIT;
    else        ctx <= ctx_nxt;
  end

`ifdef DET_RR_SCHED_CNT_EN
  // Saturating detection counter, cleared with the context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= 8'd0;
    else if (clr)                  cnt <= 8'd0;
    else if (hit && cnt != 8'hff)  cnt <= cnt + 8'd1;
  end
`endif

endmodule

module det_rr_sched #(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] i_req,
  input  logic [NCH-1:0] i_bit,
  input  logic [NCH-1:0] i_clr,
  output logic [NCH-1:0] o_gnt,
  output logic           o_det,
  output logic [1:0]     o_det_ch
`ifdef DET_RR_SCHED_CNT_EN
  ,
  input  logic [1:0]     i_cnt_sel,
  output logic [7:0]     o_cnt
`endif
);

  logic [1:0]     ptr;
  logic [1:0]     gidx;
  logic           found;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] hit;
`ifdef DET_RR_SCHED_CNT_EN
  logic [NCH-1:0][7:0] cnt;
`endif

  assign elig = i_req & ~i_clr;

  // Round-robin search starting at ptr; grant is held off entirely in reset
  always_comb begin
    found = 1'b0;
    gidx  = 2'd0;
    o_gnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && elig[ptr + 2'(i)]) begin
        found = 1'b1;
        gidx  = ptr + 2'(i);
      end
    end
    if (found && rst_n) o_gnt[gidx] = 1'b1;
  end

  det_rr_lane u_lane [NCH-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .gnt   (o_gnt),
    .clr   (i_clr),
    .b     (i_bit),
    .hit   (hit)
`ifdef DET_RR_SCHED_CNT_EN
    ,
    .cnt   (cnt)
`endif
  );

  // Pointer moves past the granted channel; holds when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= 2'd0;
    else if (|o_gnt)  ptr <= gidx + 2'd1;
  end

  // One-cycle detection pulse; channel index sticks between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_det    <= 1'b0;
      o_det_ch <= 2'd0;
    end else begin
      o_det <= |hit;
      if (|hit) o_det_ch <= gidx;
    end
  end

`ifdef DET_RR_SCHED_CNT_EN
  assign o_cnt = cnt[i_cnt_sel];
`endif

endmodule

// File: doc/det_rr_sched.md
DET_RR_SCHED -- requirements
Module: det_rr_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of serial channels; supported value is 4 only.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_req  input  4  per-channel request: i_bit[k] is valid this cycle.
REQ-005 SHALL have port i_bit  input  4  per-channel serial data bit.
REQ-006 SHALL have port i_clr  input  4  per-channel context clear.
REQ-007 SHALL have port o_gnt  output  4  one-hot grant: channel whose bit is consumed at this edge.
REQ-008 SHALL have port o_det  output  1  one-cycle pulse: a channel completed pattern 1011.
REQ-009 SHALL have port o_det_ch  output  2  channel index qualified by o_det.

Function
REQ-010 SHALL time-share one overlapping-1011 Moore detector among 4 channels by keeping a 3-bit state context per channel.
REQ-011 SHALL use context states INIT, GET_1, GET_10, GET_101, GET_1011.
REQ-012 SHALL apply, for granted bit b: INIT -> b ? GET_1 : INIT; GET_1 -> b ? GET_1 : GET_10; GET_10 -> b ? GET_101 : INIT; GET_101 -> b ? GET_1011 : GET_10; GET_1011 -> b ? GET_1 : GET_10.
REQ-013 SHALL decode any unused context encoding as INIT.
REQ-014 SHALL generate o_gnt combinationally from i_req, i_clr and the round-robin pointer ptr (2 bits): grant the first channel k = ptr, ptr+1, ... (mod 4) with i_req[k]=1 and i_clr[k]=0.
REQ-015 SHALL drive o_gnt to all zeros when no channel is eligible; ptr SHALL then hold.
REQ-016 SHALL set ptr to (k+1) mod 4 at the edge where channel k is granted.
REQ-017 SHALL update only the granted channel's context at the edge; ungranted contexts hold.
REQ-018 SHALL drop bits of non-granted requesting channels; requesters hold i_req/i_bit until o_gnt[k]=1.
REQ-019 SHALL register o_det=1 and o_det_ch=k for exactly one cycle after the edge at which context k enters GET_1011; otherwise o_det=0 and o_det_ch holds its last value.
REQ-020 SHALL give latency of one cycle from granted final bit to o_det.
REQ-021 SHALL, on i_clr[k]=1, set context k to INIT at the edge; clear overrides any update of channel k and masks its grant that cycle.
REQ-022 SHALL allow clears on several channels in the same cycle as a grant to another channel.
REQ-023 SHALL produce at most one detection per cycle (only one channel granted).

Reset
REQ-024 SHALL, while rst_n=0, force all contexts to INIT, ptr=0, o_det=0, o_det_ch=0, and o_gnt=0 regardless of i_req.
REQ-025 SHALL discard any partial pattern on reset assertion mid-stream; first grant after release goes to the lowest requesting index at or above 0.

Configuration
REQ-026 SHALL support macro DET_RR_SCHED_CNT_EN.
REQ-027 SHALL, with DET_RR_SCHED_CNT_EN defined, add input i_cnt_sel (2) and output o_cnt (8): per-channel 8-bit detection counters, incremented on each detection, saturating at 255, cleared by i_clr[k] and reset; o_cnt = counter[i_cnt_sel] combinationally.
REQ-028 SHALL, without the macro, omit those ports and counters; all other behaviour identical.

Verification
REQ-029 SHALL cover: ch0 only requesting, bits 1,0,1,1 -> o_gnt=0001 each cycle, o_det=1, o_det_ch=0 one cycle after fourth bit.
REQ-030 SHALL cover: ch0 bits 1,0,1,1,0,1,1 -> two o_det pulses (overlap), after bits 4 and 7.
REQ-031 SHALL cover: i_req=1111 held 4 cycles -> grants 0001,0010,0100,1000 in order; ch2 streams interleaved still detect 1011 independently.
REQ-032 SHALL cover: ch1 at GET_101, i_clr[1]=1 with i_req[1]=1, i_bit[1]=1 -> o_gnt[1]=0, no o_det, next 1,0,1,1 on ch1 detects after fourth bit.
REQ-033 SHALL cover: rst_n asserted after ch3 received 1,0,1 -> o_gnt=0, o_det=0 during reset; after release single bit 1 on ch3 gives no o_det.
REQ-034 SHALL cover with DET_RR_SCHED_CNT_EN: 300 detections on ch2 -> o_cnt=255 with i_cnt_sel=2; i_clr[2] -> o_cnt=0 next cycle.
